// File: rtl/contador_temporizador_bcd.sv
// Two-digit BCD countdown timer (00..39) with an IDLE/RUN/PAUSE/DONE FSM.
// Drives the state code and the digit values shown by the 7-segment decoder bank.
module contador_temporizador_bcd #(
    parameter int unsigned TICK_DIV = 4,
    parameter int unsigned PRESC_W  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       load,
    input  logic [1:0] dez_ld,
    input  logic [3:0] unid_ld,
    input  logic       start,
    input  logic       pause,
    output logic [1:0] estado_out,
    output logic [1:0] dez_out,
    output logic [3:0] unid_out,
    output logic       done
);

    localparam int unsigned DEZ_W  = 2;
    localparam int unsigned UNID_W = 4;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [UNID_W-1:0]  UNID_MAX   = UNID_W'(9);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    state_t              r_state;
    logic [DEZ_W-1:0]    r_dez;
    logic [UNID_W-1:0]   r_unid;
    logic [PRESC_W-1:0]  r_presc;
    logic                r_done;

    state_t              w_state_nxt;
    logic [DEZ_W-1:0]    w_dez_nxt;
    logic [UNID_W-1:0]   w_unid_nxt;
    logic [PRESC_W-1:0]  w_presc_nxt;
    logic                w_done_nxt;

    logic [UNID_W-1:0]   w_unid_clamp;
    logic [DEZ_W-1:0]    w_dez_dec;
    logic [UNID_W-1:0]   w_unid_dec;
    logic                w_count_zero;
    logic                w_dec_zero;

    // Preset clamp, zero detect and one-step BCD decrement of the current count
    always_comb begin
        w_unid_clamp = (unid_ld > UNID_MAX) ? UNID_MAX : unid_ld;
        w_count_zero = (r_dez == '0) && (r_unid == '0);
        w_dez_dec    = r_dez;
        w_unid_dec   = r_unid;
        if (r_unid != '0) begin
            w_unid_dec = r_unid - UNID_W'(1);
        end else if (r_dez != '0) begin
            w_unid_dec = UNID_MAX;
            w_dez_dec  = r_dez - DEZ_W'(1);
        end
        w_dec_zero = (w_dez_dec == '0) && (w_unid_dec == '0);
    end

    // State register and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_dez   <= '0;
            r_unid  <= '0;
            r_presc <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_dez   <= w_dez_nxt;
            r_unid  <= w_unid_nxt;
            r_presc <= w_presc_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Next-state logic; control priority is clear > load > pause > start
    always_comb begin
        w_state_nxt = r_state;
        w_dez_nxt   = r_dez;
        w_unid_nxt  = r_unid;
        w_presc_nxt = r_presc;
        w_done_nxt  = 1'b0;

        if (clear) begin
            w_state_nxt = ST_IDLE;
            w_dez_nxt   = '0;
            w_unid_nxt  = '0;
            w_presc_nxt = '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (load) begin
                        w_dez_nxt  = dez_ld;
                        w_unid_nxt = w_unid_clamp;
                    end else if (!pause && start && !w_count_zero) begin
                        w_state_nxt = ST_RUN;
                        w_presc_nxt = '0;
                    end
                end
                ST_RUN: begin
                    // Pause freezes the prescaler, even on a wrap cycle
                    if (pause) begin
                        w_state_nxt = ST_PAUSE;
                    end else if (r_presc == PRESC_LAST) begin
                        w_presc_nxt = '0;
                        w_dez_nxt   = w_dez_dec;
                        w_unid_nxt  = w_unid_dec;
                        if (w_dec_zero) begin
                            w_state_nxt = ST_DONE;
                            w_done_nxt  = 1'b1;
                        end
                    end else begin
                        w_presc_nxt = r_presc + PRESC_W'(1);
                    end
                end
                ST_PAUSE: begin
                    // Resume keeps the partial prescaler count
                    if (!pause && start) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (load) begin
                        w_state_nxt = ST_IDLE;
                        w_dez_nxt   = dez_ld;
                        w_unid_nxt  = w_unid_clamp;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    assign estado_out = r_state;
    assign dez_out    = r_dez;
    assign unid_out   = r_unid;
    assign done       = r_done;

endmodule

// File: tb/tb_contador_temporizador_bcd.sv
// Directed bench for the BCD countdown timer: one instance with TICK_DIV=4, one with TICK_DIV=1.
module tb_contador_temporizador_bcd;

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic       load;
    logic [1:0] dez_ld;
    logic [3:0] unid_ld;
    logic       start;
    logic       pause;

    logic [1:0] estado_out;
    logic [1:0] dez_out;
    logic [3:0] unid_out;
    logic       done;

    logic [1:0] estado_out_t1;
    logic [1:0] dez_out_t1;
    logic [3:0] unid_out_t1;
    logic       done_t1;

    int n_checks;
    int n_errors;

    contador_temporizador_bcd #(.TICK_DIV(4), .PRESC_W(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .load       (load),
        .dez_ld     (dez_ld),
        .unid_ld    (unid_ld),
        .start      (start),
        .pause      (pause),
        .estado_out (estado_out),
        .dez_out    (dez_out),
        .unid_out   (unid_out),
        .done       (done)
    );

    contador_temporizador_bcd #(.TICK_DIV(1), .PRESC_W(2)) dut_t1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .load       (load),
        .dez_ld     (dez_ld),
        .unid_ld    (unid_ld),
        .start      (start),
        .pause      (pause),
        .estado_out (estado_out_t1),
        .dez_out    (dez_out_t1),
        .unid_out   (unid_out_t1),
        .done       (done_t1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check the TICK_DIV=4 instance: state, BCD count as decimal, done
    task automatic chk_main(input string tag, input int st, input int cnt, input int dn);
        chk({tag, ".estado"}, int'(estado_out), st);
        chk({tag, ".count"}, int'(dez_out) * 10 + int'(unid_out), cnt);
        chk({tag, ".done"}, int'(done), dn);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        clear    = 1'b0;
        load     = 1'b0;
        dez_ld   = 2'd0;
        unid_ld  = 4'd0;
        start    = 1'b0;
        pause    = 1'b0;

        // Reset values
        #12;
        chk_main("reset", 0, 0, 0);
        rst_n = 1'b1;
        step();
        chk_main("post_reset", 0, 0, 0);

        // Load with units clamp 12 -> 9
        load = 1'b1; dez_ld = 2'd2; unid_ld = 4'd12;
        step();
        load = 1'b0;
        chk_main("load_clamp", 0, 29, 0);

        // Countdown from 11
        load = 1'b1; dez_ld = 2'd1; unid_ld = 4'd1;
        step();
        load = 1'b0;
        chk_main("load_11", 0, 11, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk_main("run_entry", 1, 11, 0);
        repeat (3) step();
        chk_main("before_first_dec", 1, 11, 0);
        step();
        chk_main("first_dec", 1, 10, 0);
        repeat (4) step();
        chk_main("second_dec", 1, 9, 0);
        repeat (35) step();
        chk_main("cycle43", 1, 1, 0);
        step();
        chk_main("reach_zero", 3, 0, 1);
        step();
        chk_main("done_one_cycle", 3, 0, 0);

        // DONE ignores start; load returns to IDLE
        start = 1'b1;
        step();
        start = 1'b0;
        chk_main("done_start_ignored", 3, 0, 0);
        load = 1'b1; dez_ld = 2'd0; unid_ld = 4'd5;
        step();
        load = 1'b0;
        chk_main("done_load", 0, 5, 0);

        // Pause with prescaler at 2, then resume
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        pause = 1'b1;
        step();
        chk_main("pause_entry", 2, 5, 0);
        repeat (19) step();
        chk_main("pause_frozen", 2, 5, 0);
        start = 1'b1;
        step();
        chk_main("pause_wins", 2, 5, 0);
        pause = 1'b0;
        step();
        start = 1'b0;
        chk_main("resume", 1, 5, 0);
        step();
        chk_main("resume_plus1", 1, 5, 0);
        step();
        chk_main("resume_plus2", 1, 4, 0);

        // Pause on the wrap cycle: no decrement
        repeat (3) step();
        chk_main("pre_wrap", 1, 4, 0);
        pause = 1'b1;
        step();
        pause = 1'b0;
        chk_main("pause_on_wrap", 2, 4, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk_main("resume_at_wrap", 1, 4, 0);
        step();
        chk_main("wrap_after_resume", 1, 3, 0);

        // clear beats pause
        clear = 1'b1; pause = 1'b1;
        step();
        clear = 1'b0; pause = 1'b0;
        chk_main("clear_pause", 0, 0, 0);

        // Start at 00 ignored
        start = 1'b1;
        step();
        start = 1'b0;
        chk_main("start_at_zero", 0, 0, 0);

        // load beats start
        load = 1'b1; start = 1'b1; dez_ld = 2'd3; unid_ld = 4'd9;
        step();
        load = 1'b0; start = 1'b0;
        chk_main("load_start", 0, 39, 0);

        // Asynchronous reset mid-RUN at 27
        load = 1'b1; dez_ld = 2'd2; unid_ld = 4'd7;
        step();
        load = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk_main("run_27", 1, 27, 0);
        rst_n = 1'b0;
        #1;
        chk_main("async_reset", 0, 0, 0);
        #1;
        rst_n = 1'b1;
        step();
        chk_main("after_reset_idle", 0, 0, 0);

        // TICK_DIV=1 countdown 03 -> 00
        load = 1'b1; dez_ld = 2'd0; unid_ld = 4'd3;
        step();
        load = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t1.entry_state", int'(estado_out_t1), 1);
        chk("t1.entry_count", int'(unid_out_t1), 3);
        step();
        chk("t1.count2", int'(unid_out_t1), 2);
        step();
        chk("t1.count1", int'(unid_out_t1), 1);
        step();
        chk("t1.count0", int'(dez_out_t1) * 10 + int'(unid_out_t1), 0);
        chk("t1.state_done", int'(estado_out_t1), 3);
        chk("t1.done_pulse", int'(done_t1), 1);
        step();
        chk("t1.done_low", int'(done_t1), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
